// File: rtl/lock_sequencer.sv
// Canal-lock sequencer: accepts boat arrivals, levels the chamber through the
// water-control block and drives the two gates so a gate only opens at its level.
module lock_sequencer #(
  parameter int GATE_CYCLES   = 20,
  parameter int ENTER_TIMEOUT = 200,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic arrive_low,
  input  logic arrive_high,
  input  logic boat_in_lock,
  input  logic water_high,
  input  logic water_low,
  output logic w_up,
  output logic w_down,
  output logic gate_low_open,
  output logic gate_high_open,
  output logic busy,
  output logic dir_up
);

  // Handshake with water control: a request (w_up/w_down) is held until the
  // flag of the level being left deasserts, then dropped while the target flag
  // is awaited. A request is never issued when the target flag is already high.

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_OPEN_IN, S_WAIT_IN, S_CLOSE_IN,
    S_CROSS, S_OPEN_OUT, S_WAIT_OUT, S_CLOSE_OUT
  } state_t;

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ENTER_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;
  logic             r_dir;
  logic             r_up;
  logic             r_down;
  logic             r_glo;
  logic             r_gho;
  logic             r_busy;

  logic w_pick_up;
  logic w_entry_flag;
  logic w_exit_flag;
  logic w_req;
  logic w_ack;
  logic w_gate_done;

  // Both sides waiting: serve the side matching the level; low side if unknown.
  assign w_pick_up    = arrive_low & (~arrive_high | water_low | ~water_high);
  assign w_entry_flag = r_dir ? water_low  : water_high;
  assign w_exit_flag  = r_dir ? water_high : water_low;
  assign w_req        = r_up | r_down;
  assign w_ack        = r_up ? ~water_low : ~water_high;
  assign w_gate_done  = (r_cnt == GATE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_dir   <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_glo   <= 1'b0;
      r_gho   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (arrive_low | arrive_high) begin
            r_state <= S_PREP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_abort <= 1'b0;
            r_dir   <= w_pick_up;
            r_up    <= ~w_pick_up & ~water_high;
            r_down  <= w_pick_up & ~water_low;
          end
        end
        S_PREP: begin
          if (w_req) begin
            if (w_ack) begin
              r_up   <= 1'b0;
              r_down <= 1'b0;
            end
          end else if (w_entry_flag) begin
            r_state <= S_OPEN_IN;
            r_cnt   <= '0;
            r_glo   <= r_dir;
            r_gho   <= ~r_dir;
          end
        end
        S_OPEN_IN: begin
          if (w_gate_done) begin
            r_state <= S_WAIT_IN;
            r_cnt   <= '0;
          end
        end
        S_WAIT_IN: begin
          if (boat_in_lock || r_cnt == TO_LAST) begin
            r_state <= S_CLOSE_IN;
            r_cnt   <= '0;
            r_abort <= ~boat_in_lock;
            r_glo   <= 1'b0;
            r_gho   <= 1'b0;
          end
        end
        S_CLOSE_IN: begin
          if (w_gate_done) begin
            r_cnt <= '0;
            if (r_abort) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_CROSS;
              r_up    <= r_dir & ~water_high;
              r_down  <= ~r_dir & ~water_low;
            end
          end
        end
        S_CROSS: begin
          if (w_req) begin
            if (w_ack) begin
              r_up   <= 1'b0;
              r_down <= 1'b0;
            end
          end else if (w_exit_flag) begin
            r_state <= S_OPEN_OUT;
            r_cnt   <= '0;
            r_glo   <= ~r_dir;
            r_gho   <= r_dir;
          end
        end
        S_OPEN_OUT: begin
          if (w_gate_done) begin
            r_state <= S_WAIT_OUT;
            r_cnt   <= '0;
          end
        end
        S_WAIT_OUT: begin
          // No timeout here: the gate stays open until the chamber is empty.
          if (!boat_in_lock) begin
            r_state <= S_CLOSE_OUT;
            r_cnt   <= '0;
            r_glo   <= 1'b0;
            r_gho   <= 1'b0;
          end
        end
        S_CLOSE_OUT: begin
          if (w_gate_done) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_up           = r_up;
  assign w_down         = r_down;
  assign gate_low_open  = r_glo;
  assign gate_high_open = r_gho;
  assign busy           = r_busy;
  assign dir_up         = r_dir;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: behavioural water/boat environment, a procedural
// transit model producing expected outputs, and per-cycle comparison.
module tb_lock_sequencer;

  localparam int G = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arrive_low = 1'b0;
  logic arrive_high = 1'b0;
  logic boat_in_lock = 1'b0;
  logic water_high;
  logic water_low;
  logic w_up, w_down, gate_low_open, gate_high_open, busy, dir_up;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  lock_sequencer #(.GATE_CYCLES(G), .ENTER_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .arrive_low(arrive_low), .arrive_high(arrive_high),
    .boat_in_lock(boat_in_lock),
    .water_high(water_high), .water_low(water_low),
    .w_up(w_up), .w_down(w_down),
    .gate_low_open(gate_low_open), .gate_high_open(gate_high_open),
    .busy(busy), .dir_up(dir_up)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // water level environment: 0 low, 1 between, 2 high
  int lvl = 0;
  bit moving = 0;
  int mv_to = 0, mv_cnt = 0, ack_cnt = 0, ack_d = 3;
  assign water_low  = (lvl == 0);
  assign water_high = (lvl == 2);

  always @(negedge clk) begin
    if (moving) begin
      mv_cnt--;
      if (mv_cnt <= 0) begin
        lvl = mv_to;
        moving = 0;
      end
    end else if ((w_up && lvl != 2) || (w_down && lvl != 0)) begin
      if (lvl == 1) begin
        moving = 1; mv_to = w_up ? 2 : 0; mv_cnt = $urandom_range(2, 6);
      end else begin
        ack_cnt++;
        if (ack_cnt >= ack_d) begin
          lvl = 1; ack_cnt = 0; ack_d = $urandom_range(3, 5);
          moving = 1; mv_to = w_up ? 2 : 0; mv_cnt = $urandom_range(2, 6);
        end
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // reference model: a transit walked through as a procedure
  logic e_up = 0, e_down = 0, e_glo = 0, e_gho = 0, e_busy = 0, e_dir = 0;
  bit m_rst = 0;

  task automatic m_step();
    @(posedge clk);
    if (reset) begin
      m_rst = 1;
      e_up = 0; e_down = 0; e_glo = 0; e_gho = 0; e_busy = 0; e_dir = 0;
    end
  endtask

  task automatic m_wait(input int n);
    for (int i = 0; i < n; i++) begin
      m_step();
      if (m_rst) return;
    end
  endtask

  task automatic m_level(input bit to_high);
    if (!(to_high ? water_high : water_low)) begin
      if (to_high) e_up = 1; else e_down = 1;
    end
    forever begin
      m_step();
      if (m_rst) return;
      if (e_up || e_down) begin
        if (!(to_high ? water_low : water_high)) begin e_up = 0; e_down = 0; end
      end else if (to_high ? water_high : water_low) begin
        return;
      end
    end
  endtask

  task automatic m_transit();
    bit up;
    bit aborted;
    if (arrive_low && arrive_high) up = water_low ? 1'b1 : (water_high ? 1'b0 : 1'b1);
    else up = arrive_low;
    e_busy = 1; e_dir = up;
    m_level(!up);
    if (m_rst) return;
    if (up) e_glo = 1; else e_gho = 1;
    m_wait(G);
    if (m_rst) return;
    aborted = 1;
    for (int k = 1; k <= T; k++) begin
      m_step();
      if (m_rst) return;
      if (boat_in_lock) begin aborted = 0; break; end
    end
    e_glo = 0; e_gho = 0;
    m_wait(G);
    if (m_rst) return;
    if (aborted) begin e_busy = 0; return; end
    m_level(up);
    if (m_rst) return;
    if (up) e_gho = 1; else e_glo = 1;
    m_wait(G);
    if (m_rst) return;
    do m_step(); while (!m_rst && boat_in_lock);
    if (m_rst) return;
    e_glo = 0; e_gho = 0;
    m_wait(G);
    if (m_rst) return;
    e_busy = 0;
  endtask

  initial begin
    forever begin
      m_rst = 0;
      m_step();
      if (m_rst) continue;
      if (arrive_low || arrive_high) m_transit();
    end
  end

  // scoreboard: every cycle, outputs against the model plus invariants
  always @(negedge clk) begin
    if (chk_en) begin
      check("w_up", w_up, e_up);
      check("w_down", w_down, e_down);
      check("gate_low_open", gate_low_open, e_glo);
      check("gate_high_open", gate_high_open, e_gho);
      check("busy", busy, e_busy);
      if (e_busy) check("dir_up", dir_up, e_dir);
      check("inv_two_gates", gate_low_open & gate_high_open, 0);
      check("inv_up_and_down", w_up & w_down, 0);
      check("inv_gate_level", (gate_low_open & ~water_low) | (gate_high_open & ~water_high), 0);
    end
  end

  // driver tasks
  function automatic logic sig(input int sel);
    case (sel)
      0: return busy;
      1: return gate_low_open;
      2: return gate_high_open;
      3: return w_up;
      default: return w_down;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int bound, input string name);
    int n = 0;
    while (sig(sel) !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, sig(sel) === val, 1);
  endtask

  task automatic finish_transit(input bit from_low, input bit boat);
    if (boat) begin
      wait_sig(from_low ? 1 : 2, 1'b1, 300, "entry_gate_open");
      repeat ($urandom_range(0, 8)) @(negedge clk);
      boat_in_lock = 1;
      wait_sig(from_low ? 2 : 1, 1'b1, 300, "exit_gate_open");
      repeat ($urandom_range(0, 5)) @(negedge clk);
      boat_in_lock = 0;
    end
    wait_sig(0, 1'b0, 300, "busy_fall");
  endtask

  task automatic start_transit(input bit from_low);
    if (from_low) arrive_low = 1; else arrive_high = 1;
    wait_sig(0, 1'b1, 10, "busy_rise");
    arrive_low = 0; arrive_high = 0;
  endtask

  initial begin
    int cnt, ups, downs, reqs, b, g;
    repeat (3) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    // 1: idle at low, low-side arrival: no level request, gate opens next cycle
    start_transit(1);
    check("s1_dir_up", dir_up, 1);
    cnt = 0; reqs = 0;
    while (!gate_low_open && cnt < 50) begin
      reqs += int'(w_up | w_down);
      @(negedge clk);
      cnt++;
    end
    check("s1_open_latency", cnt, 1);
    check("s1_no_request", reqs, 0);
    finish_transit(1, 1);
    check("s1_level_high", water_high, 1);

    // back to low level
    start_transit(0);
    finish_transit(0, 1);

    // 2: idle at low, high-side arrival: raise first, never lower before entry
    start_transit(0);
    ups = 0; downs = 0; cnt = 0;
    while (!gate_high_open && cnt < 200) begin
      ups += int'(w_up); downs += int'(w_down);
      @(negedge clk);
      cnt++;
    end
    check("s2_dir_up", dir_up, 0);
    check("s2_no_down_before_entry", downs, 0);
    check("s2_up_seen", ups > 0, 1);
    finish_transit(0, 1);
    check("s2_level_low", water_low, 1);

    // 3: both sides at low level: low first, high held and served next
    arrive_low = 1; arrive_high = 1;
    wait_sig(0, 1'b1, 10, "s3_busy_rise");
    check("s3_first_dir_up", dir_up, 1);
    arrive_low = 0;
    finish_transit(1, 1);
    wait_sig(0, 1'b1, 10, "s3_second_busy_rise");
    check("s3_second_dir_up", dir_up, 0);
    arrive_high = 0;
    finish_transit(0, 1);

    // 4: no boat enters: timeout, gate closes, back to idle without w_up
    start_transit(1);
    b = 1; g = 0; ups = 0; cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      b += int'(busy); g += int'(gate_low_open); ups += int'(w_up);
      cnt++;
    end
    check("s4_busy_cycles", b, 1 + G + T + G);
    check("s4_gate_cycles", g, G + T);
    check("s4_no_up", ups, 0);
    check("s4_idle", busy, 0);

    // 5: reset in CROSS while w_up is held
    start_transit(1);
    wait_sig(1, 1'b1, 300, "s5_entry_gate");
    boat_in_lock = 1;
    wait_sig(3, 1'b1, 300, "s5_up_in_cross");
    reset = 1;
    @(negedge clk);
    check("s5_all_zero", {w_up, w_down, gate_low_open, gate_high_open, busy, dir_up}, 0);
    @(negedge clk);
    reset = 0;
    boat_in_lock = 0;
    repeat (3) @(negedge clk);
    check("s5_still_idle", busy, 0);
    check("s5_level_low", water_low, 1);

    // randomized transits
    for (int i = 0; i < 24; i++) begin
      bit side, boat;
      side = 1'($urandom_range(0, 1));
      boat = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start_transit(side);
      finish_transit(side, boat);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
